// File: rtl/seq_array_mult.sv
// seq_array_mult: sequential shift-and-add array multiplier.
// One partial-product row is accumulated per cycle, so a product is ready
// WIDTH cycles after its operands are accepted. The input side uses a
// valid/ready handshake, as does the output side.
// Optional feature: define SEQ_ARRAY_MULT_SIGNED_EN to honour sgn, which
// selects two's-complement operands. Without it, every operation is unsigned.
module seq_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last_row;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            sgn_q;
  logic            sgn_eff;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   row;
  logic [PW-1:0]   acc_nxt;

  // The signed mode is only active when the feature is built in.
  assign sgn_eff  = SIGNED_EN & sgn_q;
  assign last_row = (cnt == CW'(WIDTH - 1));

  // Partial-product row for the current cnt, and the next accumulator value.
  // In signed mode, the top multiplier bit carries negative weight, so its
  // row is subtracted.
  always_comb begin
    a_ext   = sgn_eff ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    row     = b_q[cnt] ? (a_ext << cnt) : '0;
    acc_nxt = (sgn_eff && last_row) ? (acc - row) : (acc + row);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_row) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, row accumulation and product register. Reset takes
  // priority, so an accept attempted during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      p     <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= sgn;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= last_row ? '0 : cnt + 1'b1;
      if (last_row) begin
        p <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Testbench for seq_array_mult (WIDTH = 4). It applies directed vectors from
// a table, runs handshake corner sequences, and applies randomized operations
// that are checked against an arithmetic reference model.
module tb_seq_array_mult;

  localparam int W = 4;

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  seq_array_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           vs;
    logic [2*W-1:0] vp;
  } vec_t;

  vec_t vecs[$];

  // Reference: the exact integer product, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    int ix;
    int iy;
    int prod;
    if (SIGNED_BUILD && s) begin
      ix = int'($signed(x));
      iy = int'($signed(y));
    end else begin
      ix = int'(x);
      iy = int'(y);
    end
    prod = ix * iy;
    return prod[2*W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Run one operation from IDLE. While the operation runs, the operand
  // inputs are scrambled. The result is then held for 'hold' cycles with
  // out_ready low before the consumer takes it.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input int hold, input logic [2*W-1:0] exp, input string nm);
    int n;
    bit seen;
    bit bad;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    sgn       = ts;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    bad  = 1'b0;
    while (n < 4 * W + 4 && !seen) begin
      a         = W'($urandom);
      b         = W'($urandom);
      sgn       = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      n++;
      if (out_valid) seen = 1'b1;
      else if (in_ready || !busy) bad = 1'b1;
    end
    out_ready = 1'b0;
    check({nm, " latency"}, 64'(n), 64'(W));
    check({nm, " p"}, 64'(p), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      step();
      if (out_valid !== 1'b1 || p !== exp || in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, " run/hold flags"}, 64'(bad), 64'(0));
    check({nm, " idle ov/busy/ir"}, 64'({out_valid, busy, in_ready}), 64'(3'b001));
    step();
    check({nm, " p retained"}, 64'(p), 64'(exp));
  endtask

  initial begin
    int n;
    bit seen;
    bit bad;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    logic [2*W-1:0] keep;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sgn       = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset ov/busy/ir", 64'({out_valid, busy, in_ready}), 64'(3'b001));
    check("reset p", 64'(p), 64'(0));

    // Directed vectors.
    vecs.push_back('{4'hF, 4'hF, 1'b0, 8'hE1});
    vecs.push_back('{4'h6, 4'h0, 1'b0, 8'h00});
    vecs.push_back('{4'h3, 4'h5, 1'b0, 8'h0F});
    vecs.push_back('{4'h7, 4'h2, 1'b0, 8'h0E});
    vecs.push_back('{4'h1, 4'hF, 1'b0, 8'h0F});
    vecs.push_back('{4'h0, 4'h0, 1'b0, 8'h00});
    vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40});
    vecs.push_back('{4'h8, 4'h7, 1'b1, SIGNED_BUILD ? 8'hC8 : 8'h38});
    vecs.push_back('{4'hF, 4'h1, 1'b1, SIGNED_BUILD ? 8'hFF : 8'h0F});
    vecs.push_back('{4'hF, 4'hF, 1'b1, SIGNED_BUILD ? 8'h01 : 8'hE1});
    foreach (vecs[i]) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vs, i % 3, vecs[i].vp, $sformatf("vec%0d", i));
    end

    // The result is held while the consumer stalls, and in_ready rises
    // together with out_ready.
    do_op(4'h6, 4'h0, 1'b0, 3, 8'h00, "stall");
    do_op(4'h6, 4'h5, 1'b0, 0, 8'h1E, "setup");
    in_valid = 1'b1; a = 4'h2; b = 4'h2; sgn = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (W) step();
    check("stall ir low", 64'({out_valid, in_ready}), 64'(2'b10));
    out_ready = 1'b1;
    #1;
    check("stall ir follows or", 64'(in_ready), 64'(1));
    step();
    out_ready = 1'b0;

    // Back-to-back operations, with in_valid held high throughout.
    in_valid = 1'b1; a = 4'h3; b = 4'h5; sgn = 1'b0; out_ready = 1'b1;
    step();
    a = 4'h7; b = 4'h2;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      seen = out_valid;
    end
    check("b2b first latency", 64'(n), 64'(W));
    check("b2b first p", 64'(p), 64'(8'h0F));
    check("b2b first ir", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    check("b2b no bubble", 64'({busy, out_valid}), 64'(2'b10));
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      seen = out_valid;
    end
    check("b2b second latency", 64'(n), 64'(W));
    check("b2b second p", 64'(p), 64'(8'h0E));
    step();
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation.
    in_valid = 1'b1; a = 4'hA; b = 4'hB; sgn = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun rst state", 64'({busy, out_valid, in_ready}), 64'(3'b001));
    check("midrun rst p", 64'(p), 64'(0));
    bad = 1'b0;
    repeat (3 * W) begin
      step();
      if (out_valid || busy) bad = 1'b1;
    end
    check("midrun no out_valid", 64'(bad), 64'(0));

    // An accept attempted while rst is high is ignored.
    in_valid = 1'b1; a = 4'h5; b = 4'h5; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("accept during rst", 64'({busy, in_ready}), 64'(2'b01));

    // Randomized operations, checked against the model.
    keep = '0;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      keep = model(ra, rb, rs);
      do_op(ra, rb, rs, $urandom_range(0, 2), keep, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
